// File: rtl/mem_axi_master.sv
// Single-outstanding CPU-to-AXI bridge: turns one CPU read or write request
// into a single-beat AXI transaction and reports completion with a done pulse.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

module mem_axi_master #(
    parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      req,
    input  logic                      we,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    input  logic [3:0]                wstrb,
    output logic                      stall,
    output logic [31:0]               rdata,
    output logic                      done,
    output logic                      err,
    output logic [`AXI_ID_BITS-1:0]   ARID,
    output logic [31:0]               ARADDR,
    output logic [`AXI_LEN_BITS-1:0]  ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [`AXI_ID_BITS-1:0]   RID,
    input  logic [31:0]               RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY,
    output logic [`AXI_ID_BITS-1:0]   AWID,
    output logic [31:0]               AWADDR,
    output logic [`AXI_LEN_BITS-1:0]  AWLEN,
    output logic [2:0]                AWSIZE,
    output logic [1:0]                AWBURST,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [31:0]               WDATA,
    output logic [3:0]                WSTRB,
    output logic                      WLAST,
    output logic                      WVALID,
    input  logic                      WREADY,
    input  logic [`AXI_ID_BITS-1:0]   BID,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,
    output logic [2:0]                dbg_state
);

    // Handshakes: a beat transfers on a rising edge where VALID & READY are both
    // high; VALID is driven from registered state only and, once raised, holds
    // with stable payload until that transfer.
    typedef enum logic [2:0] {IDLE = 3'd0, AR = 3'd1, R = 3'd2, WR = 3'd3, B = 3'd4} state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic        done_q, err_q;
    logic        aw_pend, w_pend;
    logic        accept, aw_ok, w_ok;
    logic        unused_ids;

    assign unused_ids = ^{RID, BID};

    assign accept = (state == IDLE) && req && !done_q;
    // A channel counts as finished if it already handshook or does so this cycle.
    assign aw_ok  = !aw_pend || AWREADY;
    assign w_ok   = !w_pend  || WREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = we ? WR : AR;
            AR:      if (ARREADY) state_nx = R;
            R:       if (RVALID) state_nx = IDLE;
            WR:      if (aw_ok && w_ok) state_nx = B;
            B:       if (BVALID) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            rdata_q <= 32'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
                aw_pend <= we;
                w_pend  <= we;
            end
            if (state == WR) begin
                if (AWREADY) aw_pend <= 1'b0;
                if (WREADY)  w_pend  <= 1'b0;
            end
            if (state == R && RVALID) begin
                rdata_q <= RDATA;
                err_q   <= (RRESP != 2'b00) || !RLAST;
                done_q  <= 1'b1;
            end
            if (state == B && BVALID) begin
                err_q  <= (BRESP != 2'b00);
                done_q <= 1'b1;
            end
        end
    end

    assign stall     = (state != IDLE) || (req && !done_q);
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state;

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = '0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign ARVALID = (state == AR);
    assign RREADY  = (state == R);

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = '0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign AWVALID = (state == WR) && aw_pend;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WVALID  = (state == WR) && w_pend;
    assign WLAST   = WVALID;
    assign BREADY  = (state == B);

endmodule

// File: tb/tb_mem_axi_master.sv
// Directed bench for mem_axi_master: tasks play the AXI slave cycle by cycle,
// a done-triggered monitor scores {err, rdata} against an expected queue.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

module tb_mem_axi_master;

    logic                     ACLK, ARESETn;
    logic                     req, we;
    logic [31:0]              addr, wdata;
    logic [3:0]               wstrb;
    logic                     stall, done, err;
    logic [31:0]              rdata;
    logic [`AXI_ID_BITS-1:0]  ARID, AWID, RID, BID;
    logic [31:0]              ARADDR, AWADDR, RDATA, WDATA;
    logic [`AXI_LEN_BITS-1:0] ARLEN, AWLEN;
    logic [2:0]               ARSIZE, AWSIZE, dbg_state;
    logic [1:0]               ARBURST, AWBURST, RRESP, BRESP;
    logic                     ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic                     AWVALID, AWREADY, WLAST, WVALID, WREADY;
    logic [3:0]               WSTRB;
    logic                     BVALID, BREADY;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;
    logic        prev_done = 1'b0;
    logic        nxt_we;
    logic [31:0] nxt_addr, nxt_wdata;
    logic [3:0]  nxt_wstrb;

    mem_axi_master #(.MASTER_ID(4'd5)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .stall(stall), .rdata(rdata), .done(done), .err(err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY), .dbg_state(dbg_state)
    );

    // clock / reset
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // drive point just after the active edge, sample point on the falling edge
    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic smp();
        @(negedge ACLK);
    endtask

    // scoreboard monitor
    always @(negedge ACLK) begin
        if (ARESETn && done) begin
            logic [32:0] e;
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL done_unexpected: got done=1 expected no completion");
            end else begin
                e = exp_q.pop_front();
                if ({err, rdata} === e) pass_cnt++;
                else $display("FAIL done_resp: got err=%0b rdata=%h expected err=%0b rdata=%h",
                              err, rdata, e[32], e[31:0]);
            end
            chk("done_one_cycle", prev_done, 1'b0);
        end
        prev_done = done;
    end

    task automatic do_read(input logic [31:0] a, input int ar_delay, input logic [31:0] d,
                           input logic [1:0] resp, input logic last, input logic e_err,
                           input bit hold);
        cyc();
        req = 1'b1; we = 1'b0; addr = a; wdata = 32'hFFFF_FFFF;
        smp();
        chk("rd_req_stall", stall, 1'b1);
        chk("rd_idle_arvalid", ARVALID, 1'b0);
        chk("err_hold", err, last_err);
        chk("rdata_hold", rdata, last_rdata);
        for (int i = 0; i <= ar_delay; i++) begin
            cyc();
            ARREADY = (i == ar_delay);
            smp();
            chk("ar_valid", ARVALID, 1'b1);
            chk("ar_addr", ARADDR, a);
            chk("ar_state", dbg_state, 3'd1);
            chk("ar_rready", RREADY, 1'b0);
        end
        cyc();
        ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = d; RRESP = resp; RLAST = last; RID = 4'hF;
        exp_q.push_back({e_err, d});
        smp();
        chk("r_arvalid_low", ARVALID, 1'b0);
        chk("r_rready", RREADY, 1'b1);
        chk("r_stall", stall, 1'b1);
        chk("ar_fixed", {ARID, ARLEN, ARSIZE, ARBURST}, {4'd5, 8'd0, 3'b010, 2'b01});
        cyc();
        RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00; RLAST = 1'b0;
        if (hold) begin
            we = nxt_we; addr = nxt_addr; wdata = nxt_wdata; wstrb = nxt_wstrb;
        end else begin
            req = 1'b0;
        end
        smp();
        chk("rd_done_rready", RREADY, 1'b0);
        chk("rd_done_stall", stall, 1'b0);
        chk("rd_done_state", dbg_state, 3'd0);
        chk("rd_done_valids", {ARVALID, AWVALID}, 2'b00);
        last_rdata = d;
        last_err = e_err;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_d, input int w_d, input logic [1:0] resp,
                            input logic e_err);
        int n;
        n = (aw_d > w_d) ? aw_d : w_d;
        cyc();
        req = 1'b1; we = 1'b1; addr = a; wdata = d; wstrb = s;
        smp();
        chk("wr_req_stall", stall, 1'b1);
        chk("wr_idle_valids", {AWVALID, WVALID}, 2'b00);
        chk("err_hold", err, last_err);
        chk("rdata_hold", rdata, last_rdata);
        for (int k = 0; k <= n; k++) begin
            cyc();
            AWREADY = (k == aw_d);
            WREADY  = (k == w_d);
            smp();
            chk("aw_valid", AWVALID, (k <= aw_d));
            chk("w_valid", WVALID, (k <= w_d));
            chk("aw_addr", AWADDR, a);
            chk("w_payload", {WDATA, WSTRB}, {d, s});
            if (k <= w_d) chk("w_last", WLAST, 1'b1);
            chk("wr_bready", BREADY, 1'b0);
            chk("wr_state", dbg_state, 3'd3);
        end
        cyc();
        AWREADY = 1'b0; WREADY = 1'b0;
        BVALID = 1'b1; BRESP = resp; BID = 4'hA;
        exp_q.push_back({e_err, last_rdata});
        smp();
        chk("b_valids_low", {AWVALID, WVALID}, 2'b00);
        chk("b_bready", BREADY, 1'b1);
        chk("b_state", dbg_state, 3'd4);
        chk("aw_fixed", {AWID, AWLEN, AWSIZE, AWBURST}, {4'd5, 8'd0, 3'b010, 2'b01});
        cyc();
        BVALID = 1'b0; BRESP = 2'b00;
        req = 1'b0;
        smp();
        chk("wr_done_bready", BREADY, 1'b0);
        chk("wr_done_stall", stall, 1'b0);
        chk("wr_done_state", dbg_state, 3'd0);
        last_err = e_err;
    endtask

    initial begin
        ARESETn = 1'b0;
        req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
        ARREADY = 1'b0; RID = '0; RDATA = 32'h0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = 2'b00; BVALID = 1'b0;
        nxt_we = 1'b0; nxt_addr = 32'h0; nxt_wdata = 32'h0; nxt_wstrb = 4'h0;

        smp();
        chk("rst_state", dbg_state, 3'd0);
        chk("rst_valids", {ARVALID, AWVALID, WVALID}, 3'b000);
        chk("rst_readys", {RREADY, BREADY}, 2'b00);
        chk("rst_done_err", {done, err}, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addr", ARADDR, 32'h0);
        chk("rst_stall", stall, 1'b0);
        cyc();
        ARESETn = 1'b1;

        // read, ARREADY after 3 wait cycles (ARADDR held 4 cycles)
        do_read(32'h0000_1004, 3, 32'hDEAD_BEEF, 2'b00, 1'b1, 1'b0, 1'b0);
        // write, AW and W accepted in the same cycle
        do_write(32'h0000_2000, 32'h1234_5678, 4'b0011, 0, 0, 2'b00, 1'b0);
        // write, W accepted two cycles before AW
        do_write(32'h0000_3008, 32'hA5A5_5A5A, 4'b1111, 2, 0, 2'b00, 1'b0);
        // read with SLVERR, request held across done into a write with DECERR
        nxt_we = 1'b1; nxt_addr = 32'h0000_5000; nxt_wdata = 32'h0BAD_F00D; nxt_wstrb = 4'b1000;
        do_read(32'h0000_4000, 0, 32'hCAFE_F00D, 2'b10, 1'b1, 1'b1, 1'b1);
        do_write(32'h0000_5000, 32'h0BAD_F00D, 4'b1000, 0, 1, 2'b11, 1'b1);
        // read with OKAY but RLAST missing flags an error
        do_read(32'h0000_6000, 1, 32'h1122_3344, 2'b00, 1'b0, 1'b1, 1'b0);

        // reset while waiting in R
        cyc();
        req = 1'b1; we = 1'b0; addr = 32'h0000_6100;
        smp();
        cyc();
        ARREADY = 1'b1;
        smp();
        chk("abort_arvalid", ARVALID, 1'b1);
        cyc();
        ARREADY = 1'b0;
        smp();
        chk("abort_in_r", {dbg_state, RREADY}, {3'd2, 1'b1});
        cyc();
        ARESETn = 1'b0;
        req = 1'b0;
        #1;
        chk("abort_rready_async", RREADY, 1'b0);
        chk("abort_state_async", dbg_state, 3'd0);
        smp();
        chk("abort_rdata_err", {err, rdata}, 33'h0);
        chk("abort_addr", ARADDR, 32'h0);
        cyc();
        ARESETn = 1'b1;
        last_rdata = 32'h0;
        last_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("abort_no_done", done, 1'b0);
            chk("abort_idle", dbg_state, 3'd0);
            cyc();
        end
        // next request after the abort starts cleanly in AR
        do_read(32'h0000_7000, 1, 32'h55AA_55AA, 2'b00, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) cyc();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
